mac_vec_seq: RTL and testbench
==============================

# mac_vec_seq

Sequencer that time-shares one fixed-point multiply-accumulate datapath to compute a matrix-vector product y[r] = b[r] + Σk m[r][k]·x[k] for ROWS rows of VEC_LEN terms each. It sits in the mlops layer between synchronous-read weight/activation/bias memories and the downstream consumer. It generates read addresses, runs the accumulator pipeline, rescales each row result to the output format, and hands rows out over a valid/ready handshake.

## Interface
- IW, 8, integer bits of m, x, b, y (signed, includes sign)
- QW, 8, fraction bits of m, x, b, y
- VEC_LEN, 4, terms per row (≥1)
- ROWS, 2, rows per run (≥1)
- clk_in  in  1  clock
- rstn_in  in  1  reset; synchronous, active-low
- start_in  in  1  start a run; sampled only in IDLE
- busy_out  out  1  high from first RUN cycle through DONE
- done_out  out  1  one-cycle pulse after the last row handshakes
- rd_en_out  out  1  memory read enable, high only in RUN
- w_addr_out  out  $clog2(ROWS*VEC_LEN)  weight address = row*VEC_LEN + k
- x_addr_out  out  $clog2(VEC_LEN)  activation address = k
- b_addr_out  out  $clog2(ROWS)  bias address = row
- w_data_in, x_data_in, b_data_in  in  IW+QW  read data, valid 1 cycle after address
- y_data_out  out  IW+QW  row result
- y_row_out  out  $clog2(ROWS)  row index of y_data_out
- y_valid_out  out  1  result valid
- y_ready_in  in  1  consumer accepts

## Operation
- FSM states: IDLE, RUN, FLUSH, OUT, DONE.
- IDLE goes to RUN when start_in=1. Row and k are cleared.
- RUN: drive addresses for (row, k) with rd_en_out=1, then increment k. After k=VEC_LEN-1, go to FLUSH.
- Pipeline stage 1: one cycle after each RUN address cycle, compute p = w·x. The product is 2(IW+QW) bits wide with 2QW fraction bits.
  - For the first term: acc = sext(b<<QW) + p.
  - For later terms: acc = acc + p.
- Accumulator width is 2(IW+QW) + $clog2(VEC_LEN) + 1. The accumulator does not overflow internally.
- FLUSH: the last product is accumulated. Go to OUT.
- OUT: y_data_out = resize(acc >>> QW), where the shift is arithmetic (truncation toward −∞). y_valid_out=1.
  - On y_valid_out & y_ready_in: if row = ROWS-1, go to DONE; otherwise increment row, clear k, and go to RUN.
  - While y_ready_in=0: y_data_out and y_row_out are held stable.
- DONE: done_out=1 for one cycle, then go to IDLE.
- start_in outside IDLE is ignored.
- Reset values: all outputs 0, FSM in IDLE, acc 0. A reset mid-run aborts the run with no partial output.

## Timing
- start_in seen at edge t gives RUN during cycles t+1 … t+VEC_LEN.
- FLUSH is at t+VEC_LEN+1.
- OUT begins at t+VEC_LEN+2 (y_valid_out=1).
- With y_ready_in held at 1, the row period is VEC_LEN+2 cycles.
- done_out is asserted ROWS·(VEC_LEN+2)+1 cycles after start.
- Address outputs are 0 whenever rd_en_out=0.
- Memory read latency is exactly 1 cycle. No stall path exists on the read side.

## Configuration
- MAC_VEC_SEQ_SAT_EN defined: resize saturates to the output range.
  - Positive overflow gives 0x7F…F.
  - Negative overflow gives 0x80…0.
- MAC_VEC_SEQ_SAT_EN undefined: resize keeps the low IW+QW bits (two's-complement wrap).

## Test plan
- IW=QW=8, VEC_LEN=4, ROWS=1. All m=0x0100, x=[1,2,3,4] (0x0100…0x0400), b=0x0080, start at t -> y_data_out=0x0A80 (10.5), y_valid_out at t+6, done_out at t+7.
- Same setup with m=0xFF00 (−1.0), x=0x0080 (0.5) on all terms, b=0 -> y_data_out=0xFE00 (−2.0).
- ROWS=2, y_ready_in low for 3 cycles during row 0 OUT -> y_data_out/y_row_out stay stable, row 1 RUN starts the cycle after the handshake, y_row_out=1 for the second result.
- All m=x=0x7F00, b=0, VEC_LEN=4 -> y_data_out=0x7FFF with MAC_VEC_SEQ_SAT_EN, 0x0400 without.
- rstn_in low for one cycle during RUN -> next cycle busy_out=0, y_valid_out=0, rd_en_out=0. A fresh start then reproduces the first scenario's result exactly.
- start_in pulsed during RUN and OUT -> ignored; exactly ROWS results and one done_out.

Source files
------------

// File: rtl/mac_vec_seq.sv
// Matrix-vector MAC sequencer: one shared multiply-accumulate walks ROWS x VEC_LEN terms.
// Define MAC_VEC_SEQ_SAT_EN to saturate row results instead of wrapping them.
module mac_vec_seq #(
    parameter int IW      = 8,
    parameter int QW      = 8,
    parameter int VEC_LEN = 4,
    parameter int ROWS    = 2,
    localparam int DW  = IW + QW,
    localparam int WAW = (ROWS * VEC_LEN > 1) ? $clog2(ROWS * VEC_LEN) : 1,
    localparam int KW  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1,
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic           clk_in,
    input  logic           rstn_in,
    input  logic           start_in,
    output logic           busy_out,
    output logic           done_out,
    output logic           rd_en_out,
    output logic [WAW-1:0] w_addr_out,
    output logic [KW-1:0]  x_addr_out,
    output logic [RW-1:0]  b_addr_out,
    input  logic [DW-1:0]  w_data_in,
    input  logic [DW-1:0]  x_data_in,
    input  logic [DW-1:0]  b_data_in,
    output logic [DW-1:0]  y_data_out,
    output logic [RW-1:0]  y_row_out,
    output logic           y_valid_out,
    input  logic           y_ready_in
);
    localparam int PW = 2 * DW;
    localparam int AW = PW + $clog2(VEC_LEN) + 1;

    typedef enum logic [2:0] {IDLE, RUN, FLUSH, OUT, DONE} state_t;

    state_t               state;
    logic [RW-1:0]        row;
    logic                 mac_vld;
    logic                 mac_first;
    logic signed [AW-1:0] acc;

    logic signed [PW-1:0]    prod;
    logic signed [DW+QW-1:0] b_sh;
    logic signed [AW-1:0]    acc_nxt;
    logic [DW-1:0]           y_res;

    // Read data arrives one cycle after its address, so the MAC runs one stage behind RUN.
    assign prod    = PW'($signed(w_data_in)) * PW'($signed(x_data_in));
    assign b_sh    = {b_data_in, {QW{1'b0}}};
    assign acc_nxt = (mac_first ? AW'(b_sh) : acc) + AW'(prod);

`ifdef MAC_VEC_SEQ_SAT_EN
    logic signed [AW-1:0] sh;
    assign sh = acc_nxt >>> QW;
    always_comb begin
        y_res = sh[DW-1:0];
        if (sh[AW-1:DW-1] != {(AW-DW+1){sh[AW-1]}})
            y_res = sh[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
`else
    assign y_res = DW'(acc_nxt >>> QW);
`endif

    always_ff @(posedge clk_in) begin
        if (!rstn_in) begin
            state       <= IDLE;
            row         <= '0;
            mac_vld     <= 1'b0;
            mac_first   <= 1'b0;
            acc         <= '0;
            busy_out    <= 1'b0;
            done_out    <= 1'b0;
            rd_en_out   <= 1'b0;
            w_addr_out  <= '0;
            x_addr_out  <= '0;
            b_addr_out  <= '0;
            y_data_out  <= '0;
            y_row_out   <= '0;
            y_valid_out <= 1'b0;
        end else begin
            done_out  <= 1'b0;
            mac_vld   <= rd_en_out;
            mac_first <= rd_en_out && (x_addr_out == '0);
            if (mac_vld)
                acc <= acc_nxt;

            case (state)
                IDLE: begin
                    row <= '0;
                    if (start_in) begin
                        state      <= RUN;
                        busy_out   <= 1'b1;
                        rd_en_out  <= 1'b1;
                        w_addr_out <= '0;
                        x_addr_out <= '0;
                        b_addr_out <= '0;
                    end
                end
                RUN: begin
                    // x_addr_out doubles as the term counter k.
                    if (x_addr_out == KW'(VEC_LEN - 1)) begin
                        state      <= FLUSH;
                        rd_en_out  <= 1'b0;
                        w_addr_out <= '0;
                        x_addr_out <= '0;
                        b_addr_out <= '0;
                    end else begin
                        w_addr_out <= w_addr_out + 1'b1;
                        x_addr_out <= x_addr_out + 1'b1;
                    end
                end
                FLUSH: begin
                    state       <= OUT;
                    y_valid_out <= 1'b1;
                    y_data_out  <= y_res;
                    y_row_out   <= row;
                end
                OUT: begin
                    if (y_ready_in) begin
                        y_valid_out <= 1'b0;
                        if (row == RW'(ROWS - 1)) begin
                            state    <= DONE;
                            done_out <= 1'b1;
                        end else begin
                            state      <= RUN;
                            row        <= row + 1'b1;
                            rd_en_out  <= 1'b1;
                            w_addr_out <= WAW'((int'(row) + 1) * VEC_LEN);
                            x_addr_out <= '0;
                            b_addr_out <= row + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_vec_seq.sv
// Directed bench for mac_vec_seq (IW=QW=8, VEC_LEN=4, ROWS=2) with synchronous-read memory models.
module tb_mac_vec_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, start, busy, done, rd_en, y_valid, ready;
    logic [2:0]  w_addr;
    logic [1:0]  x_addr;
    logic [0:0]  b_addr, y_row;
    logic [15:0] w_data, x_data, b_data, y_data;
    logic [15:0] w_mem [8];
    logic [15:0] x_mem [4];
    logic [15:0] b_mem [2];
    int checks = 0, failures = 0, n = 0, res_cnt = 0, done_cnt = 0;

    mac_vec_seq #(.IW(8), .QW(8), .VEC_LEN(4), .ROWS(2)) dut (
        .clk_in(clk), .rstn_in(rstn), .start_in(start), .busy_out(busy), .done_out(done),
        .rd_en_out(rd_en), .w_addr_out(w_addr), .x_addr_out(x_addr), .b_addr_out(b_addr),
        .w_data_in(w_data), .x_data_in(x_data), .b_data_in(b_data),
        .y_data_out(y_data), .y_row_out(y_row), .y_valid_out(y_valid), .y_ready_in(ready)
    );

    always @(posedge clk) begin
        w_data <= w_mem[w_addr];
        x_data <= x_mem[x_addr];
        b_data <= b_mem[b_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        n++;
    endtask

    task automatic go();
        n = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic set_row(input int r, input logic [15:0] m, input logic [15:0] b);
        for (int k = 0; k < 4; k++) w_mem[r*4+k] = m;
        b_mem[r] = b;
    endtask

    task automatic load_a();
        set_row(0, 16'h0100, 16'h0080);
        set_row(1, 16'hFF00, 16'h0100);
        for (int k = 0; k < 4; k++) x_mem[k] = 16'((k + 1) * 256);
    endtask

    // Row 1 of scenario A: -1.0 * (1+2+3+4) + 1.0 = -9.0
    localparam logic [15:0] A_Y1 = 16'hF700;
`ifdef MAC_VEC_SEQ_SAT_EN
    localparam logic [15:0] B_Y1 = 16'h7FFF, D_Y0 = 16'h7FFF, D_Y1 = 16'h8000;
`else
    localparam logic [15:0] B_Y1 = 16'hFE00, D_Y0 = 16'h0400, D_Y1 = 16'hFC00;
`endif

    initial begin
        rstn = 1'b0; start = 1'b0; ready = 1'b1;
        load_a();
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd", rd_en, 1'b0);
        chk("rst_valid", y_valid, 1'b0);
        chk("rst_y", y_data, 16'h0);
        chk("rst_waddr", w_addr, 3'd0);
        rstn = 1'b1;
        step();

        // A: two rows, consumer always ready
        go();
        chk("a_busy", busy, 1'b1);
        chk("a_rd1", rd_en, 1'b1);
        repeat (3) step();
        chk("a_waddr3", w_addr, 3'd3);
        chk("a_xaddr3", x_addr, 2'd3);
        step();
        chk("a_flush_rd", rd_en, 1'b0);
        chk("a_flush_waddr", w_addr, 3'd0);
        chk("a_flush_valid", y_valid, 1'b0);
        step();
        chk("a_valid0", y_valid, 1'b1);
        chk("a_y0", y_data, 16'h0A80);
        chk("a_row0", y_row, 1'b0);
        step();
        chk("a_r1_rd", rd_en, 1'b1);
        chk("a_r1_waddr", w_addr, 3'd4);
        chk("a_r1_baddr", b_addr, 1'b1);
        chk("a_r1_valid", y_valid, 1'b0);
        repeat (5) step();
        chk("a_valid1", y_valid, 1'b1);
        chk("a_y1", y_data, A_Y1);
        chk("a_row1", y_row, 1'b1);
        step();
        chk("a_done", done, 1'b1);
        chk("a_busy_done", busy, 1'b1);
        step();
        chk("a_done_pulse", done, 1'b0);
        chk("a_idle_busy", busy, 1'b0);

        // C: back-pressure on row 0 for three edges
        ready = 1'b0;
        go();
        repeat (5) step();
        chk("c_valid6", y_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("c_hold_valid", y_valid, 1'b1);
            chk("c_hold_y", y_data, 16'h0A80);
            chk("c_hold_row", y_row, 1'b0);
        end
        chk("c_hold_rd", rd_en, 1'b0);
        ready = 1'b1;
        step();
        chk("c_r1_valid", y_valid, 1'b0);
        chk("c_r1_rd", rd_en, 1'b1);
        chk("c_r1_baddr", b_addr, 1'b1);
        repeat (5) step();
        chk("c_valid1", y_valid, 1'b1);
        chk("c_row1", y_row, 1'b1);
        chk("c_y1", y_data, A_Y1);
        step();
        chk("c_done", done, 1'b1);
        step();

        // R: reset mid-RUN aborts, then a clean rerun
        go();
        step();
        rstn = 1'b0;
        step();
        chk("r_busy", busy, 1'b0);
        chk("r_valid", y_valid, 1'b0);
        chk("r_rd", rd_en, 1'b0);
        rstn = 1'b1;
        step();
        go();
        repeat (5) step();
        chk("r_valid0", y_valid, 1'b1);
        chk("r_y0", y_data, 16'h0A80);
        repeat (8) step();
        chk("r_idle", busy, 1'b0);

        // B: negative fractional product, row 1 overflows positive
        set_row(0, 16'hFF00, 16'h0000);
        set_row(1, 16'h7F00, 16'h0000);
        for (int k = 0; k < 4; k++) x_mem[k] = 16'h0080;
        go();
        repeat (5) step();
        chk("b_y0", y_data, 16'hFE00);
        repeat (6) step();
        chk("b_y1", y_data, B_Y1);
        repeat (2) step();

        // D: large positive and negative sums
        set_row(0, 16'h7F00, 16'h0000);
        set_row(1, 16'h8100, 16'h0000);
        for (int k = 0; k < 4; k++) x_mem[k] = 16'h7F00;
        go();
        repeat (5) step();
        chk("d_y0", y_data, D_Y0);
        repeat (6) step();
        chk("d_y1", y_data, D_Y1);
        repeat (2) step();

        // S: start pulses during RUN and OUT are ignored
        load_a();
        go();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (y_valid && ready) res_cnt++;
            if (done) done_cnt++;
            start = y_valid && (y_row == 1'b0);
        end
        start = 1'b0;
        chk("s_results", res_cnt, 2);
        chk("s_dones", done_cnt, 1);
        chk("s_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
